regfile_read_arbiter: RTL and testbench

Sequencing arbiter sharing the single 16-entry × 16-bit register-file read multiplexer among four requesters. Arbitrates pending requests, drives the mux select, captures the selected word one cycle later and returns it with a one-cycle acknowledge. Sits between the register-file mux and the datapath units (ALU operand fetch, store unit, debug port, etc.) that need read access.

---
 rtl/regfile_read_arbiter_if.sv | 28 ++
 rtl/regfile_read_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_read_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Bundles the request, register-file mux and read-return signals between
// the datapath requesters (master) and regfile_read_arbiter (slave).
interface regfile_read_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic [3:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] mux_a;
  logic [ADDR_W-1:0] sel;
  logic [3:0]        gnt;
  logic [3:0]        ack;
  logic [DATA_W-1:0] dout;
  logic              busy;

  modport master (
    output req, addr0, addr1, addr2, addr3, mux_a,
    input  sel, gnt, ack, dout, busy
  );

  modport slave (
    input  req, addr0, addr1, addr2, addr3, mux_a,
    output sel, gnt, ack, dout, busy
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read mux among four requesters; define RF_ARB_RR_EN
// for round-robin arbitration, otherwise fixed priority (requester 0 highest).
//
// Handshake: req[i] rises and stays high with addr_i stable until ack[i]
// pulses for one cycle; dout is valid only in that ack cycle. gnt shows
// which requester currently owns sel; sel keeps its last value while gnt=0.
module regfile_read_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_read_arbiter_if.slave  bus,
  output logic                   fsm_state
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  logic [0:0]        state;
  logic [3:0]        cand;
  logic              found;
  logic [1:0]        win;
  logic [ADDR_W-1:0] win_addr;

  // The owner whose data is captured this cycle is masked out of the next pick.
  always_comb begin
    cand = bus.req;
    if (state == READ) cand = bus.req & ~bus.gnt;
  end

`ifdef RF_ARB_RR_EN
  logic [1:0] ptr;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= 2'd0;
    else if (found) ptr <= win + 2'd1;
  end
`else
  always_comb begin
    found = 1'b0;
    win   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!found && cand[i]) begin
        found = 1'b1;
        win   = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    case (win)
      2'd0:    win_addr = bus.addr0;
      2'd1:    win_addr = bus.addr1;
      2'd2:    win_addr = bus.addr2;
      default: win_addr = bus.addr3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.sel  <= '0;
      bus.gnt  <= 4'd0;
      bus.ack  <= 4'd0;
      bus.dout <= '0;
    end else begin
      bus.ack <= 4'd0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.sel <= win_addr;
            bus.gnt <= 4'b0001 << win;
            state   <= READ;
          end else begin
            bus.gnt <= 4'd0;
          end
        end
        default: begin
          bus.dout <= bus.mux_a;
          bus.ack  <= bus.gnt;
          if (found) begin
            bus.sel <= win_addr;
            bus.gnt <= 4'b0001 << win;
          end else begin
            bus.gnt <= 4'd0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy  = (state == READ);
  assign fsm_state = state;
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter; expected ack orders follow the
// RF_ARB_RR_EN setting the bench is compiled with.
module tb_regfile_read_arbiter;
  logic        clk;
  logic        rst_n;
  logic        fsm_state;
  logic [15:0] regs [16];
  int          vectors;
  int          miscompares;

  regfile_read_arbiter_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  assign bus.mux_a = regs[bus.sel];

  regfile_read_arbiter #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    bus.req   = 4'd0;
    bus.addr0 = 4'd0;
    bus.addr1 = 4'd0;
    bus.addr2 = 4'd0;
    bus.addr3 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    do_reset();
    vectors += 6;
    if (bus.sel !== 4'd0) begin miscompares++; $display("FAIL reset_sel: got %h expected 0", bus.sel); end
    if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    if (bus.ack !== 4'd0) begin miscompares++; $display("FAIL reset_ack: got %b expected 0000", bus.ack); end
    if (bus.dout !== 16'h0) begin miscompares++; $display("FAIL reset_dout: got %h expected 0000", bus.dout); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (fsm_state !== 1'b0) begin miscompares++; $display("FAIL reset_state: got %b expected 0", fsm_state); end
  endtask

  task automatic test_single_read;
    do_reset();
    regs[5]   = 16'hBEEF;
    bus.addr1 = 4'd5;
    bus.req   = 4'b0010;
    tick();
    vectors += 4;
    if (bus.sel !== 4'd5) begin miscompares++; $display("FAIL single_sel: got %h expected 5", bus.sel); end
    if (bus.gnt !== 4'b0010) begin miscompares++; $display("FAIL single_gnt: got %b expected 0010", bus.gnt); end
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    if (bus.ack !== 4'd0) begin miscompares++; $display("FAIL single_early_ack: got %b expected 0000", bus.ack); end
    tick();
    vectors += 5;
    if (bus.ack !== 4'b0010) begin miscompares++; $display("FAIL single_ack: got %b expected 0010", bus.ack); end
    if (bus.dout !== 16'hBEEF) begin miscompares++; $display("FAIL single_dout: got %h expected beef", bus.dout); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_idle_busy: got %b expected 0", bus.busy); end
    if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL single_idle_gnt: got %b expected 0000", bus.gnt); end
    if (bus.sel !== 4'd5) begin miscompares++; $display("FAIL single_sel_hold: got %h expected 5", bus.sel); end
    bus.req = 4'd0;
    tick();
    vectors++;
    if (bus.ack !== 4'd0) begin miscompares++; $display("FAIL single_ack_clear: got %b expected 0000", bus.ack); end
  endtask

  task automatic test_all_four;
    do_reset();
    for (int i = 0; i < 4; i++) regs[i] = 16'h100 + 16'(i);
    bus.addr0 = 4'd0; bus.addr1 = 4'd1; bus.addr2 = 4'd2; bus.addr3 = 4'd3;
    bus.req   = 4'b1111;
    tick();
    vectors++;
    if (bus.gnt !== 4'b0001) begin miscompares++; $display("FAIL all4_first_gnt: got %b expected 0001", bus.gnt); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors += 2;
      if (bus.ack !== (4'b0001 << k)) begin miscompares++; $display("FAIL all4_ack%0d: got %b expected %b", k, bus.ack, 4'b0001 << k); end
      if (bus.dout !== 16'h100 + 16'(k)) begin miscompares++; $display("FAIL all4_dout%0d: got %h expected %h", k, bus.dout, 16'h100 + 16'(k)); end
      bus.req = bus.req & ~bus.ack;
    end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL all4_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_fairness;
    logic [3:0]  exp_ack;
    logic [15:0] exp_dout;
    do_reset();
    regs[3] = 16'h3333; regs[7] = 16'h7777;
    bus.addr0 = 4'd3; bus.addr3 = 4'd7;
    bus.req   = 4'b1001;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_ack  = (k % 2 == 0) ? 4'b0001 : 4'b1000;
      exp_dout = (k % 2 == 0) ? 16'h3333 : 16'h7777;
      vectors += 2;
      if (bus.ack !== exp_ack) begin miscompares++; $display("FAIL fair_ack%0d: got %b expected %b", k, bus.ack, exp_ack); end
      if (bus.dout !== exp_dout) begin miscompares++; $display("FAIL fair_dout%0d: got %h expected %h", k, bus.dout, exp_dout); end
    end
    bus.req = 4'd0;
    tick();
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL fair_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_arb_order;
    logic [3:0] exp_first;
    logic [3:0] exp_second;
`ifdef RF_ARB_RR_EN
    exp_first = 4'b0100; exp_second = 4'b0001;
`else
    exp_first = 4'b0001; exp_second = 4'b0100;
`endif
    do_reset();
    regs[1] = 16'h1111; regs[2] = 16'h2222; regs[4] = 16'h4444;
    bus.addr0 = 4'd1; bus.addr1 = 4'd2; bus.addr2 = 4'd4;
    bus.req   = 4'b0010;
    tick();
    tick();
    bus.req = 4'b0101;
    tick();
    vectors++;
    if (bus.gnt !== exp_first) begin miscompares++; $display("FAIL order_gnt: got %b expected %b", bus.gnt, exp_first); end
    tick();
    vectors++;
    if (bus.ack !== exp_first) begin miscompares++; $display("FAIL order_ack1: got %b expected %b", bus.ack, exp_first); end
    bus.req = bus.req & ~bus.ack;
    tick();
    vectors++;
    if (bus.ack !== exp_second) begin miscompares++; $display("FAIL order_ack2: got %b expected %b", bus.ack, exp_second); end
    bus.req = 4'd0;
    tick();
  endtask

  task automatic test_regrant;
    logic [3:0] exp_ack [5];
    int         n0;
`ifdef RF_ARB_RR_EN
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0100, 4'b1000};
`endif
    do_reset();
    for (int i = 0; i < 4; i++) regs[i] = 16'h100 + 16'(i);
    bus.addr0 = 4'd0; bus.addr1 = 4'd1; bus.addr2 = 4'd2; bus.addr3 = 4'd3;
    bus.req   = 4'b1111;
    n0 = 0;
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (bus.ack !== exp_ack[k]) begin miscompares++; $display("FAIL regrant_ack%0d: got %b expected %b", k, bus.ack, exp_ack[k]); end
      if (bus.ack[0]) n0++;
      if (bus.ack[0] && n0 == 2) bus.req[0] = 1'b0;
      bus.req = bus.req & ~(bus.ack & 4'b1110);
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL regrant_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_single_held;
    logic [3:0] exp_ack;
    do_reset();
    regs[15]  = 16'hFFFF;
    bus.addr0 = 4'd15;
    bus.req   = 4'b0001;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_ack = (k % 2 == 0) ? 4'b0001 : 4'b0000;
      vectors++;
      if (bus.ack !== exp_ack) begin miscompares++; $display("FAIL held_ack%0d: got %b expected %b", k, bus.ack, exp_ack); end
      if (k % 2 == 0) begin
        vectors++;
        if (bus.dout !== 16'hFFFF) begin miscompares++; $display("FAIL held_dout%0d: got %h expected ffff", k, bus.dout); end
      end
    end
    bus.req = 4'd0;
    tick();
    tick();
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL held_idle: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    regs[15]  = 16'hFFFF;
    bus.addr0 = 4'd15;
    bus.req   = 4'b0001;
    tick();
    tick();
    bus.req = 4'd0;
    tick();
    bus.req = 4'b0001;
    tick();
    vectors += 2;
    if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.busy); end
    if (bus.dout !== 16'hFFFF) begin miscompares++; $display("FAIL midrst_pre_dout: got %h expected ffff", bus.dout); end
    rst_n = 1'b0;
    #1;
    vectors += 5;
    if (bus.sel !== 4'd0) begin miscompares++; $display("FAIL midrst_sel: got %h expected 0", bus.sel); end
    if (bus.gnt !== 4'd0) begin miscompares++; $display("FAIL midrst_gnt: got %b expected 0000", bus.gnt); end
    if (bus.dout !== 16'h0) begin miscompares++; $display("FAIL midrst_dout: got %h expected 0000", bus.dout); end
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    if (bus.ack !== 4'd0) begin miscompares++; $display("FAIL midrst_ack: got %b expected 0000", bus.ack); end
    tick();
    vectors++;
    if (bus.ack !== 4'd0) begin miscompares++; $display("FAIL midrst_no_ack: got %b expected 0000", bus.ack); end
    bus.req = 4'd0;
    rst_n   = 1'b1;
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req     = 4'd0;
    test_reset();
    test_single_read();
    test_all_four();
    test_fairness();
    test_arb_order();
    test_regrant();
    test_single_held();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
